// File: rtl/vdec_hs_part2_collect.sv
// HS-SCCH part-2 bit collector: assembles info/CRC fields from serial decoded bits,
// removes the UE-ID mask from the CRC field, launches the CRC checker and returns the verdict.
module vdec_hs_part2_collect #(
  parameter int INFO_MAX = 21,
  parameter int CRC_W    = 16,
  parameter int BIT_REV  = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_frame_start,
  input  logic [4:0]          i_info_len,
  input  logic [CRC_W-1:0]    i_ue_id,
  input  logic                i_bit_vld,
  input  logic                i_bit_in,
  output logic                o_crc_start,
  output logic [INFO_MAX-1:0] o_info_bits,
  output logic [CRC_W-1:0]    o_crc_bits,
  output logic [4:0]          o_crc_len,
  input  logic                i_crc_done,
  input  logic                i_crc_match,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_part2_ok,
  output logic [INFO_MAX-1:0] o_info_out
);

  localparam int CW = $clog2(INFO_MAX + CRC_W);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_LAUNCH, S_WAIT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [4:0]          r_len;
  logic [CRC_W-1:0]    r_ue_id;
  logic [INFO_MAX-1:0] r_info;
  logic [CRC_W-1:0]    r_crcraw;
  logic                r_crc_start;
  logic [INFO_MAX-1:0] r_info_bits;
  logic [CRC_W-1:0]    r_crc_bits;
  logic [4:0]          r_crc_len;
  logic                r_busy;
  logic                r_done;
  logic                r_part2_ok;
  logic [INFO_MAX-1:0] r_info_out;

  logic                w_len_legal;
  logic                w_fs_legal;
  logic                w_fs_illegal;
  logic [4:0]          w_len;
  logic [CRC_W-1:0]    w_ue_id;
  logic [CW-1:0]       w_cnt;
  logic                w_accept;
  logic [CW-1:0]       w_last_idx;
  logic                w_last;
  logic [CW-1:0]       w_tidx;
  logic                w_is_info;
  logic [CW-1:0]       w_cidx;
  logic [INFO_MAX-1:0] w_info_nxt;
  logic [CRC_W-1:0]    w_crc_nxt;
  logic                w_verdict;

  // Bit placement: a legal frame_start restarts the frame, and a bit in that cycle is bit 0.
  always_comb begin
    w_len_legal  = (i_info_len != 5'd0) && (i_info_len <= 5'(INFO_MAX));
    w_fs_legal   = i_frame_start && w_len_legal;
    w_fs_illegal = i_frame_start && !w_len_legal;
    w_len        = w_fs_legal ? i_info_len : r_len;
    w_ue_id      = w_fs_legal ? i_ue_id : r_ue_id;
    w_cnt        = w_fs_legal ? {CW{1'b0}} : r_cnt;
    w_accept     = i_bit_vld && (w_fs_legal || ((r_state == S_COLLECT) && !i_frame_start));
    w_last_idx   = CW'(w_len) + CW'(CRC_W - 1);
    w_last       = w_accept && (w_cnt == w_last_idx);
    w_tidx       = (BIT_REV != 0) ? (w_last_idx - w_cnt) : w_cnt;
    w_is_info    = (w_tidx < CW'(w_len));
    w_cidx       = CW'(CRC_W - 1) - (w_tidx - CW'(w_len));
    w_verdict    = (r_state == S_WAIT) && i_crc_done && !i_frame_start;
    w_info_nxt   = w_fs_legal ? {INFO_MAX{1'b0}} : r_info;
    w_crc_nxt    = w_fs_legal ? {CRC_W{1'b0}} : r_crcraw;
    for (int i = 0; i < INFO_MAX; i++) begin
      if (w_accept && w_is_info && (w_tidx == CW'(i))) begin
        w_info_nxt[i] = i_bit_in;
      end else begin
        w_info_nxt[i] = w_info_nxt[i];
      end
    end
    for (int i = 0; i < CRC_W; i++) begin
      if (w_accept && !w_is_info && (w_cidx == CW'(i))) begin
        w_crc_nxt[i] = i_bit_in;
      end else begin
        w_crc_nxt[i] = w_crc_nxt[i];
      end
    end
  end

  // Next-state logic; any frame_start overrides the current state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_fs_legal) begin
      w_state_nxt = w_last ? S_LAUNCH : S_COLLECT;
    end else if (w_fs_illegal) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_IDLE;
        S_COLLECT: w_state_nxt = w_last ? S_LAUNCH : S_COLLECT;
        S_LAUNCH:  w_state_nxt = S_WAIT;
        S_WAIT:    w_state_nxt = i_crc_done ? S_IDLE : S_WAIT;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, collection shift registers and registered checker/verdict outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CW{1'b0}};
      r_len       <= 5'd0;
      r_ue_id     <= {CRC_W{1'b0}};
      r_info      <= {INFO_MAX{1'b0}};
      r_crcraw    <= {CRC_W{1'b0}};
      r_crc_start <= 1'b0;
      r_info_bits <= {INFO_MAX{1'b0}};
      r_crc_bits  <= {CRC_W{1'b0}};
      r_crc_len   <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_part2_ok  <= 1'b0;
      r_info_out  <= {INFO_MAX{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_crc_start <= w_last;
      r_done      <= w_fs_illegal || w_verdict;
      if (w_fs_legal) begin
        r_len   <= i_info_len;
        r_ue_id <= i_ue_id;
      end
      if (w_fs_legal || w_accept) begin
        r_cnt    <= w_cnt + (w_accept ? CW'(1) : CW'(0));
        r_info   <= w_info_nxt;
        r_crcraw <= w_crc_nxt;
      end
      // Fields are frozen at the last accepted bit so they are stable from LAUNCH onwards.
      if (w_last) begin
        r_info_bits <= w_info_nxt;
        r_crc_bits  <= w_crc_nxt ^ w_ue_id;
        r_crc_len   <= w_len;
      end
      if (i_frame_start) begin
        r_part2_ok <= 1'b0;
        r_info_out <= {INFO_MAX{1'b0}};
      end else if (w_verdict) begin
        r_part2_ok <= i_crc_match;
        r_info_out <= r_info_bits;
      end
    end
  end

  assign o_crc_start = r_crc_start;
  assign o_info_bits = r_info_bits;
  assign o_crc_bits  = r_crc_bits;
  assign o_crc_len   = r_crc_len;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_part2_ok  = r_part2_ok;
  assign o_info_out  = r_info_out;

endmodule

// File: tb/tb_vdec_hs_part2_collect.sv
// Scoreboard bench for vdec_hs_part2_collect: the bench plays traceback source and CRC checker.
module tb_vdec_hs_part2_collect;

  localparam int BIT_REV = 1;

  typedef struct {
    logic [20:0] info;
    logic [15:0] crc;
    logic [4:0]  len;
  } launch_t;

  typedef struct {
    logic        ok;
    logic [20:0] info;
  } verdict_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic [4:0]  info_len = 5'd0;
  logic [15:0] ue_id = 16'h0;
  logic        bit_vld = 1'b0;
  logic        bit_in = 1'b0;
  logic        crc_start;
  logic [20:0] info_bits;
  logic [15:0] crc_bits;
  logic [4:0]  crc_len;
  logic        crc_done = 1'b0;
  logic        crc_match = 1'b0;
  logic        busy;
  logic        done;
  logic        part2_ok;
  logic [20:0] info_out;

  int n_vec = 0;
  int n_mis = 0;
  int n_starts = 0;
  int n_dones = 0;
  launch_t  q_launch[$];
  verdict_t q_verdict[$];

  vdec_hs_part2_collect dut (
    .i_clk(clk), .i_rst(rst), .i_frame_start(frame_start), .i_info_len(info_len),
    .i_ue_id(ue_id), .i_bit_vld(bit_vld), .i_bit_in(bit_in), .o_crc_start(crc_start),
    .o_info_bits(info_bits), .o_crc_bits(crc_bits), .o_crc_len(crc_len),
    .i_crc_done(crc_done), .i_crc_match(crc_match), .o_busy(busy), .o_done(done),
    .o_part2_ok(part2_ok), .o_info_out(info_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // CRC-16 (x^16+x^12+x^5+1), info bit 0 first; the bench's stand-in for the real checker.
  function automatic logic [15:0] crc16(input logic [20:0] d, input int len);
    logic [15:0] c;
    logic fb;
    c = 16'h0;
    for (int i = 0; i < len; i++) begin
      fb = c[15] ^ d[i];
      c = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // k-th bit delivered by the traceback, given the transmitted info and masked CRC fields.
  function automatic logic acc_bit(input int len, input logic [20:0] inf, input logic [15:0] cm,
                                   input int k);
    int j;
    j = (BIT_REV != 0) ? (len + 15 - k) : k;
    return (j < len) ? inf[j] : cm[15 - (j - len)];
  endfunction

  // Scoreboard side: pop and compare whenever the DUT launches or reports a verdict.
  always @(negedge clk) begin
    if (rst) begin
      if (crc_start) begin
        n_starts++;
        if (q_launch.size() == 0) begin
          chk("spurious_start", 64'd1, 64'd0);
        end else begin
          launch_t e;
          e = q_launch.pop_front();
          chk("info_bits", 64'(info_bits), 64'(e.info));
          chk("crc_bits", 64'(crc_bits), 64'(e.crc));
          chk("crc_len", 64'(crc_len), 64'(e.len));
        end
      end
      if (done) begin
        n_dones++;
        if (q_verdict.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          verdict_t v;
          v = q_verdict.pop_front();
          chk("part2_ok", 64'(part2_ok), 64'(v.ok));
          chk("info_out", 64'(info_out), 64'(v.info));
        end
      end
    end
  end

  task automatic run_frame(input int len, input logic [15:0] ue, input logic [20:0] info,
                           input bit flip, input bit gap, input bit fs_bit0, input bit rst_in_wait);
    logic [20:0] im;
    logic [15:0] c;
    logic [15:0] cm;
    int n;
    int k0;
    im = info & ((21'h1 << len) - 21'h1);
    c  = crc16(im, len);
    cm = c ^ ue;
    if (flip) cm[5] = ~cm[5];
    q_launch.push_back('{im, cm ^ ue, 5'(len)});
    if (!rst_in_wait) q_verdict.push_back('{!flip, im});
    n = len + 16;
    k0 = 0;
    frame_start = 1'b1;
    info_len = 5'(len);
    ue_id = ue;
    if (fs_bit0) begin
      bit_vld = 1'b1;
      bit_in = acc_bit(len, im, cm, 0);
      k0 = 1;
    end
    step();
    frame_start = 1'b0;
    bit_vld = 1'b0;
    for (int k = k0; k < n; k++) begin
      bit_vld = 1'b1;
      bit_in = acc_bit(len, im, cm, k);
      step();
      bit_vld = 1'b0;
      if (k < n - 1) begin
        chk("start_early", 64'(crc_start), 64'd0);
        if (gap) step();
      end
    end
    chk("start_lat", 64'(crc_start), 64'd1);
    step();
    chk("start_pulse", 64'(crc_start), 64'd0);
    chk("busy_wait", 64'(busy), 64'd1);
    step();
    if (rst_in_wait) begin
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("rst_ctl", 64'({crc_start, busy, done, part2_ok, crc_len}), 64'd0);
      chk("rst_info", 64'({info_bits, info_out}), 64'd0);
      chk("rst_crc", 64'(crc_bits), 64'd0);
      crc_done = 1'b1;
      crc_match = 1'b1;
      step();
      crc_done = 1'b0;
      chk("late_done", 64'(done), 64'd0);
      step();
      chk("late_done2", 64'(done), 64'd0);
    end else begin
      crc_done = 1'b1;
      crc_match = (crc_bits == crc16(info_bits, int'(crc_len)));
      step();
      crc_done = 1'b0;
      chk("done_lat", 64'(done), 64'd1);
      chk("busy_fall", 64'(busy), 64'd0);
      step();
      chk("done_pulse", 64'(done), 64'd0);
    end
  endtask

  task automatic illegal_frame(input logic [4:0] len);
    q_verdict.push_back('{1'b0, 21'h0});
    frame_start = 1'b1;
    info_len = len;
    step();
    frame_start = 1'b0;
    chk("ill_done", 64'(done), 64'd1);
    chk("ill_start", 64'(crc_start), 64'd0);
    chk("ill_busy", 64'(busy), 64'd0);
    step();
    chk("ill_pulse", 64'(done), 64'd0);
    chk("ill_start2", 64'(crc_start), 64'd0);
  endtask

  initial begin
    int s0;
    int d0;
    logic [20:0] r_info;
    rst = 1'b0;
    repeat (3) step();
    chk("reset_ctl", 64'({crc_start, busy, done, part2_ok, crc_len}), 64'd0);
    chk("reset_info", 64'({info_bits, info_out}), 64'd0);
    chk("reset_crc", 64'(crc_bits), 64'd0);
    rst = 1'b1;
    step();

    // Full-length frame, gapless, then with bit 0 in the frame_start cycle.
    run_frame(21, 16'hA5C3, 21'h15A3C7, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(21, 16'h3C5A, 21'h0F0F0F, 1'b0, 1'b0, 1'b1, 1'b0);
    // Short frame with a corrupted CRC bit.
    run_frame(6, 16'h1234, 21'h1FFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    // Same L=6 payload gapless and with bit_vld toggling.
    r_info = 21'($urandom);
    run_frame(6, 16'hBEEF, r_info, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame(6, 16'hBEEF, r_info, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_frame(int'($urandom_range(1, 21)), 16'($urandom), 21'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'b0);
    end

    // Abort an L=21 frame after 10 bits, then a clean L=6 frame.
    s0 = n_starts;
    d0 = n_dones;
    frame_start = 1'b1;
    info_len = 5'd21;
    ue_id = 16'h5555;
    step();
    frame_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bit_vld = 1'b1;
      bit_in = 1'($urandom);
      step();
    end
    bit_vld = 1'b0;
    run_frame(6, 16'h0F0F, 21'h00002D, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_starts", 64'(n_starts - s0), 64'd1);
    chk("abort_dones", 64'(n_dones - d0), 64'd1);

    // crc_done while idle is ignored.
    crc_done = 1'b1;
    crc_match = 1'b1;
    step();
    crc_done = 1'b0;
    chk("idle_crc_done", 64'(done), 64'd0);

    illegal_frame(5'd0);
    illegal_frame(5'd22);

    // Reset during WAIT, followed by a late crc_done.
    run_frame(6, 16'hA5C3, 21'h00003B, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("sb_launch_empty", 64'(q_launch.size()), 64'd0);
    chk("sb_verdict_empty", 64'(q_verdict.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
